fp_square: RTL and testbench

Single-precision IEEE-754 squarer (z = a·a) on the same stb/ack handshake as the floating-point adder and divider cores, acting as the responder. It is the inverse companion of the Newton square-root iterator. The collision pipeline uses it to form squared distances and radii, and to check sqrt results by re-squaring them. It has a multi-cycle FSM with fixed latency and back-pressure on the output.

---
 rtl/fp_pkg.sv | 28 ++
 rtl/fp_mant_mul24.sv | 51 +++++
 rtl/fp_square.sv | 162 ++++++++++++++++
 tb/tb_fp_square.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision squarer.
package fp_pkg;

  localparam int unsigned FP_W     = 32;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned EXPF_W   = 8;
  localparam int unsigned MANT_W   = 24;
  localparam int unsigned EXP_W    = 10;
  localparam int unsigned PROD_W   = 48;
  localparam int unsigned FP_BIAS  = 127;

  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [FP_W-1:0] FP_PINF = 32'h7F80_0000;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [3:0] {
    GET_A,
    UNPACK,
    SPECIAL,
    MULT_0,
    MULT_1,
    NORMALISE,
    ROUND,
    PACK,
    PUT_Z
  } fp_sq_state_t;

endpackage

// File: rtl/fp_mant_mul24.sv
// Two-stage 24x24 unsigned multiplier: registered partial products, then registered sum.
module fp_mant_mul24
  import fp_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              en_pp,
  input  logic              en_sum,
  input  logic [MANT_W-1:0] a,
  input  logic [MANT_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  localparam int unsigned HALF_W = MANT_W / 2;

  logic [HALF_W-1:0] a_hi, a_lo, b_hi, b_lo;
  logic [MANT_W-1:0] pp_hh, pp_hl, pp_lh, pp_ll;

  assign a_hi = a[MANT_W-1:HALF_W];
  assign a_lo = a[HALF_W-1:0];
  assign b_hi = b[MANT_W-1:HALF_W];
  assign b_lo = b[HALF_W-1:0];

  // Stage 1: four 12x12 partial products
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pp_hh <= '0;
      pp_hl <= '0;
      pp_lh <= '0;
      pp_ll <= '0;
    end else if (en_pp) begin
      pp_hh <= MANT_W'(a_hi) * MANT_W'(b_hi);
      pp_hl <= MANT_W'(a_hi) * MANT_W'(b_lo);
      pp_lh <= MANT_W'(a_lo) * MANT_W'(b_hi);
      pp_ll <= MANT_W'(a_lo) * MANT_W'(b_lo);
    end
  end

  // Stage 2: align and sum the partial products
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p <= '0;
    end else if (en_sum) begin
      p <= (PROD_W'(pp_hh) << MANT_W)
         + (PROD_W'(pp_hl) << HALF_W)
         + (PROD_W'(pp_lh) << HALF_W)
         +  PROD_W'(pp_ll);
    end
  end

endmodule

// File: rtl/fp_square.sv
// Single-precision IEEE-754 squarer (z = a*a) with stb/ack handshakes on both sides.
module fp_square
  import fp_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic [FP_W-1:0] input_a,
  input  logic            input_a_stb,
  output logic            input_a_ack,
  output logic [FP_W-1:0] output_z,
  output logic            output_z_stb,
  input  logic            output_z_ack
);

  fp_sq_state_t             state;
  logic [FP_W-2:0]          mag_q;
  logic [MANT_W-1:0]        m_q;
  logic signed [EXP_W-1:0]  e_q;
  logic signed [EXP_W-1:0]  exp_q;
  logic [MANT_W-1:0]        mant_q;
  logic                     g_q, r_q, s_q;
  logic [PROD_W-1:0]        prod;
  logic                     mul_pp_c, mul_sum_c;
  logic [EXPF_W-1:0]        expf;
  logic [FRAC_W-1:0]        frac;
  logic                     unused_sign;

  // The square is always non-negative, so the operand sign never matters
  assign unused_sign = input_a[FP_W-1];

  assign expf      = mag_q[FP_W-2:FRAC_W];
  assign frac      = mag_q[FRAC_W-1:0];
  assign mul_pp_c  = (state == MULT_0);
  assign mul_sum_c = (state == MULT_1);

  fp_mant_mul24 u_mul (
    .CLK    (CLK),
    .RST    (RST),
    .en_pp  (mul_pp_c),
    .en_sum (mul_sum_c),
    .a      (m_q),
    .b      (m_q),
    .p      (prod)
  );

  // Control FSM and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= GET_A;
      mag_q        <= '0;
      m_q          <= '0;
      e_q          <= '0;
      exp_q        <= '0;
      mant_q       <= '0;
      g_q          <= 1'b0;
      r_q          <= 1'b0;
      s_q          <= 1'b0;
      input_a_ack  <= 1'b0;
      output_z     <= FP_ZERO;
      output_z_stb <= 1'b0;
    end else begin
      case (state)
        GET_A: begin
          if (input_a_ack && input_a_stb) begin
            mag_q       <= input_a[FP_W-2:0];
            input_a_ack <= 1'b0;
            state       <= UNPACK;
          end else begin
            input_a_ack <= 1'b1;
          end
        end

        UNPACK: begin
          m_q   <= {1'b1, frac};
          e_q   <= $signed({2'b00, expf}) - $signed(EXP_W'(FP_BIAS));
          state <= SPECIAL;
        end

        SPECIAL: begin
          if (expf == '1 && frac != '0) begin
            output_z     <= FP_QNAN;
            output_z_stb <= 1'b1;
            state        <= PUT_Z;
          end else if (expf == '1) begin
            output_z     <= FP_PINF;
            output_z_stb <= 1'b1;
            state        <= PUT_Z;
          end else if (expf == '0) begin
            // zero and denormal operands both square to below the normal range
            output_z     <= FP_ZERO;
            output_z_stb <= 1'b1;
            state        <= PUT_Z;
          end else begin
            state <= MULT_0;
          end
        end

        MULT_0: begin
          exp_q <= (e_q <<< 1) + $signed(EXP_W'(FP_BIAS));
          state <= MULT_1;
        end

        MULT_1: begin
          state <= NORMALISE;
        end

        NORMALISE: begin
          if (prod[PROD_W-1]) begin
            mant_q <= prod[47:24];
            g_q    <= prod[23];
            r_q    <= prod[22];
            s_q    <= |prod[21:0];
            exp_q  <= exp_q + 10'sd1;
          end else begin
            mant_q <= prod[46:23];
            g_q    <= prod[22];
            r_q    <= prod[21];
            s_q    <= |prod[20:0];
          end
          state <= ROUND;
        end

        ROUND: begin
          if (g_q && (r_q || s_q || mant_q[0])) begin
            if (&mant_q) begin
              mant_q <= 24'h80_0000;
              exp_q  <= exp_q + 10'sd1;
            end else begin
              mant_q <= mant_q + 24'd1;
            end
          end
          state <= PACK;
        end

        PACK: begin
          if (exp_q >= 10'sd255) begin
            output_z <= FP_PINF;
          end else if (exp_q <= 10'sd0) begin
            output_z <= FP_ZERO;
          end else begin
            output_z <= {1'b0, exp_q[EXPF_W-1:0], mant_q[FRAC_W-1:0]};
          end
          output_z_stb <= 1'b1;
          state        <= PUT_Z;
        end

        PUT_Z: begin
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            input_a_ack  <= 1'b1;
            state        <= GET_A;
          end
        end

        default: begin
          state <= GET_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_square.sv
// Self-checking bench for fp_square: arithmetic reference model, per-cycle monitor, literal anchors.
module tb_fp_square;
  import fp_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] input_a = '0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] z;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  logic prev_stb = 1'b0;

  fp_square dut (
    .CLK          (CLK),
    .RST          (RST),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit is_special(input logic [31:0] a);
    return (a[30:23] == 8'd0) || (a[30:23] == 8'd255);
  endfunction

  // Square computed from the value: exact product, round-half-even on the remainder
  function automatic logic [31:0] model_sq(input logic [31:0] a);
    int          ex, msb, sh, unb, be;
    logic [22:0] fr;
    logic [47:0] p, qv, rem, half;
    ex = int'(a[30:23]);
    fr = a[22:0];
    if (ex == 255) return (fr != 0) ? 32'h7FC0_0000 : 32'h7F80_0000;
    if (ex == 0) return 32'h0;
    p    = 48'({1'b1, fr}) * 48'({1'b1, fr});
    msb  = p[47] ? 47 : 46;
    sh   = msb - 23;
    qv   = p >> sh;
    rem  = p - (qv << sh);
    half = 48'(1) << (sh - 1);
    unb  = 2 * (ex - 127) + (msb - 46);
    if (rem > half || (rem == half && qv[0])) qv = qv + 48'd1;
    if (qv == (48'(1) << 24)) begin
      qv  = qv >> 1;
      unb = unb + 1;
    end
    be = unb + 127;
    if (be >= 255) return 32'h7F80_0000;
    if (be <= 0) return 32'h0;
    return {1'b0, 8'(be), qv[22:0]};
  endfunction

  // Per-cycle monitor: protocol invariants, latency and result against the model
  always @(negedge CLK) begin
    if (!RST) begin
      q.delete();
      prev_stb = 1'b0;
    end else begin
      check("ack_stb_exclusive", 32'(input_a_ack && output_z_stb), 32'd0);
      if (q.size() != 0) check("ack_low_while_busy", 32'(input_a_ack), 32'd0);
      if (output_z_stb) begin
        if (q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL spurious_result: got stb with z=%h, required no result", output_z);
        end else begin
          if (!prev_stb) check("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
          check("result", output_z, q[0].z);
          if (output_z_ack) void'(q.pop_front());
        end
      end
      if (input_a_ack && input_a_stb)
        q.push_back('{model_sq(input_a), (is_special(input_a) ? 2 : 7), cyc + 1});
      prev_stb = output_z_stb;
    end
  end

  task automatic run_op(input logic [31:0] a, input int hold, input bit lit,
                        input logic [31:0] z_lit, input int lat_lit);
    int acc;
    bit seen;
    @(posedge CLK);
    #1;
    output_z_ack = (hold == 0);
    input_a      = a;
    input_a_stb  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (input_a_ack) seen = 1'b1;
    end
    if (!seen) begin
      check("accept_timeout", 32'(input_a_ack), 32'd1);
      input_a_stb = 1'b0;
      return;
    end
    @(posedge CLK);
    #1;
    acc         = cyc;
    input_a_stb = 1'b0;
    input_a     = $urandom;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (output_z_stb) seen = 1'b1;
    end
    if (!seen) begin
      check("result_timeout", 32'(output_z_stb), 32'd1);
      return;
    end
    if (lit) begin
      check("lit_result", output_z, z_lit);
      check("lit_latency", 32'(cyc - acc), 32'(lat_lit));
    end
    if (hold > 0) begin
      repeat (hold) @(negedge CLK);
      check("hold_stb", 32'(output_z_stb), 32'd1);
      check("hold_ack", 32'(input_a_ack), 32'd0);
      @(posedge CLK);
      #1 output_z_ack = 1'b1;
      @(negedge CLK);
    end
    @(negedge CLK);
    check("release_stb", 32'(output_z_stb), 32'd0);
    check("release_ack", 32'(input_a_ack), 32'd1);
  endtask

  function automatic logic [31:0] gen_operand();
    logic [31:0] a;
    a = $urandom;
    case ($urandom_range(0, 4))
      0: ;
      1: a[30:23] = 8'($urandom_range(100, 154));
      2: a[30:23] = 8'($urandom_range(186, 196));
      3: a[30:23] = 8'($urandom_range(58, 68));
      default: begin
        a[30:23] = ($urandom_range(0, 1) != 0) ? 8'd255 : 8'd0;
        if ($urandom_range(0, 1) != 0) a[22:0] = '0;
      end
    endcase
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("reset_ack", 32'(input_a_ack), 32'd0);
    check("reset_stb", 32'(output_z_stb), 32'd0);
    check("reset_z", output_z, 32'h0);
    @(posedge CLK);
    #1 RST = 1'b1;

    run_op(32'h4040_0000, 0, 1'b1, 32'h4110_0000, 7);
    run_op(32'h3FC0_0000, 0, 1'b1, 32'h4010_0000, 7);
    run_op(32'hC000_0000, 1, 1'b1, 32'h4080_0000, 7);
    run_op(32'h3F80_0001, 0, 1'b1, 32'h3F80_0002, 7);
    run_op(32'h7FC0_0001, 0, 1'b1, 32'h7FC0_0000, 2);
    run_op(32'hFF80_0000, 2, 1'b1, 32'h7F80_0000, 2);
    run_op(32'h8000_0000, 0, 1'b1, 32'h0000_0000, 2);
    run_op(32'h0000_0001, 0, 1'b1, 32'h0000_0000, 2);
    run_op(32'h60AD_78EC, 0, 1'b1, 32'h7F80_0000, 7);
    run_op(32'h1E3C_E508, 0, 1'b1, 32'h0000_0000, 7);
    run_op(32'h4040_0000, 10, 1'b1, 32'h4110_0000, 7);

    // Reset while the multiplier is summing: result must be discarded
    @(posedge CLK);
    #1;
    output_z_ack = 1'b1;
    input_a      = 32'h4040_0000;
    input_a_stb  = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge CLK);
        if (input_a_ack) seen = 1'b1;
      end
      if (!seen) check("rst_accept_timeout", 32'(input_a_ack), 32'd1);
    end
    @(posedge CLK);
    #1 input_a_stb = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    check("midrst_ack", 32'(input_a_ack), 32'd0);
    check("midrst_stb", 32'(output_z_stb), 32'd0);
    check("midrst_z", output_z, 32'h0);
    repeat (2) @(negedge CLK);
    check("midrst_z_held", output_z, 32'h0);
    @(posedge CLK);
    #1 RST = 1'b1;
    run_op(32'h4000_0000, 0, 1'b1, 32'h4080_0000, 7);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = gen_operand();
      run_op(a, $urandom_range(0, 3), 1'b0, 32'h0, 0);
    end

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
